seq_det_param: RTL

//  Parametrised serial bit-pattern detector: next generation of the fixed 4-bit

---
 rtl/seq_det_param_pkg.sv | 12 +
 rtl/seq_det_param_sat_counter.sv | 38 +++
 rtl/seq_det_param.sv | 98 +++++++++
 3 files changed

// File: rtl/seq_det_param_pkg.sv
// Shared constants for the parametrised serial pattern detector.
// Holds the power-up pattern and the overlap mode encoding.
package seq_det_pkg;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b0110;

  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } overlap_mode_e;

endpackage

// File: rtl/seq_det_param_sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky saturation flag.
// A clear takes priority over an increment in the same cycle.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count,
  output logic         o_sat
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_count;
  logic         r_sat;

  // The flag rises on the same edge that the count lands on its maximum
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_clr) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_inc && (r_count != MAX)) begin
      r_count <= r_count + 1'b1;
      if (r_count == (MAX - 1'b1)) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign o_count = r_count;
  assign o_sat   = r_sat;

endmodule

// File: rtl/seq_det_param.sv
// Serial bit-pattern detector with a runtime-loadable pattern, overlapping or
// non-overlapping detection, a registered match pulse and a saturating match count.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PAT_INIT = PAT_LEN'(DEFAULT_PATTERN),
  parameter int                 CNT_W    = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic               i_x,
  input  logic               i_pat_load,
  input  logic [PAT_LEN-1:0] i_pat_in,
  input  logic               i_overlap,
  input  logic               i_clr_count,
  output logic               o_z,
  output logic [CNT_W-1:0]   o_match_count,
  output logic               o_count_sat,
  output logic [PAT_LEN-1:0] o_pattern
);

  localparam int                FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] r_pattern;
  logic [FILL_W-1:0]  r_fill;
  logic               r_z;
  logic [PAT_LEN-1:0] w_window;
  logic               w_accept;
  logic               w_filled;
  logic               w_match;

  // The oldest history bit is shifted out before it can ever be compared, so
  // only PAT_LEN-1 bits are stored; the window is completed by the live sample.
  generate
    if (PAT_LEN == 1) begin : g_single
      assign w_window = i_x;
    end else begin : g_multi
      logic [PAT_LEN-2:0] r_history;

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          r_history <= '0;
        end else if (i_pat_load) begin
          r_history <= '0;
        end else if (i_en) begin
          r_history <= w_window[PAT_LEN-2:0];
        end
      end

      assign w_window = {r_history, i_x};
    end
  endgenerate

  assign w_accept = i_en & ~i_pat_load;
  assign w_filled = (r_fill == FILL_MAX) || (r_fill == FILL_THR);
  assign w_match  = w_accept && w_filled && (w_window == r_pattern);

  // A load wipes partial progress and drops any sample offered alongside it
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pattern <= PAT_INIT;
      r_fill    <= '0;
      r_z       <= 1'b0;
    end else if (i_pat_load) begin
      r_pattern <= i_pat_in;
      r_fill    <= '0;
      r_z       <= 1'b0;
    end else if (i_en) begin
      r_z <= w_match;
      if (w_match && (i_overlap == NON_OVERLAP)) begin
        r_fill <= '0;
      end else if (r_fill != FILL_MAX) begin
        r_fill <= r_fill + 1'b1;
      end
    end else begin
      r_z <= 1'b0;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_match),
    .i_clr   (i_clr_count),
    .o_count (o_match_count),
    .o_sat   (o_count_sat)
  );

  assign o_z       = r_z;
  assign o_pattern = r_pattern;

endmodule
